wired_index_collect: RTL and testbench

//  Inverse of the leading/trailing-zero counter: accepts a stream of bit indices (valid/ready) and rebuilds the bit vector.

---
 rtl/wired_index_collect.sv | 161 ++++++++++++++++
 tb/tb_wired_index_collect.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wired_index_collect.sv
// ----------------------------------------------------------------------------
// wired_index_collect
//
// Rebuilds a bit vector from a stream of bit indices. Every accepted index is
// decoded to a one-hot vector and OR-ed into an accumulator. The beat marked
// last closes the frame. The finished mask is then held for a consumer until
// that consumer takes it. The index-to-bit mapping (MODE) is the same as the
// leading/trailing-zero counter's, so an index from that counter decodes back
// to the bit it came from.
//
// Parameters
//   WIDTH      mask width in bits (>= 2)
//   MODE       0: index i -> bit i, 1: index i -> bit WIDTH-1-i
//   CNT_WIDTH  width of idx_i (derived, leave at default)
//   NUM_WIDTH  width of num_o (derived, leave at default)
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active-high
//   idx_valid_i   index beat valid
//   idx_ready_o   index beat accepted when valid & ready (high while collecting)
//   idx_i         bit index to set
//   idx_last_i    beat closes the current frame
//   mask_valid_o  completed frame mask available
//   mask_ready_i  consumer takes the mask when valid & ready
//   mask_o        accumulated mask (running value while collecting)
//   num_o         number of distinct bits set in mask_o
//   dup_o         frame contained an index whose bit was already set
//   err_o         frame contained an index >= WIDTH (that beat sets no bit)
// ----------------------------------------------------------------------------
module wired_index_collect #(
    parameter int   WIDTH     = 8,
    parameter logic MODE      = 1'b0,
    parameter int   CNT_WIDTH = $clog2(WIDTH),
    parameter int   NUM_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 idx_valid_i,
    output logic                 idx_ready_o,
    input  logic [CNT_WIDTH-1:0] idx_i,
    input  logic                 idx_last_i,
    output logic                 mask_valid_o,
    input  logic                 mask_ready_i,
    output logic [WIDTH-1:0]     mask_o,
    output logic [NUM_WIDTH-1:0] num_o,
    output logic                 dup_o,
    output logic                 err_o
);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     w_acc_next;
    logic [NUM_WIDTH-1:0] r_num;
    logic [NUM_WIDTH-1:0] w_num_next;
    logic                 r_dup;
    logic                 w_dup_next;
    logic                 r_err;
    logic                 w_err_next;

    logic                 w_in_range;
    logic [WIDTH-1:0]     w_hit;
    logic                 w_is_dup;

    // The index is zero-extended by one bit so that WIDTH itself is
    // representable and the comparison also works for non-power-of-two widths.
    assign w_in_range = ({1'b0, idx_i} < (CNT_WIDTH + 1)'(WIDTH));

    // One-hot decode. Each mask bit recognises the single index that maps to
    // it, which folds the MODE reversal into elaboration-time constants.
    // Out-of-range indices light no bit at all.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
            localparam int BIT_IDX = MODE ? (WIDTH - 1 - gi) : gi;
            assign w_hit[gi] = w_in_range && (idx_i == CNT_WIDTH'(BIT_IDX));
        end
    endgenerate

    assign w_is_dup = |(w_hit & r_acc);

    // Next-state and datapath update
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_num_next   = r_num;
        w_dup_next   = r_dup;
        w_err_next   = r_err;

        case (r_state)
            ST_COLLECT: begin
                if (idx_valid_i) begin
                    if (!w_in_range) begin
                        w_err_next = 1'b1;
                    end else if (w_is_dup) begin
                        w_dup_next = 1'b1;
                    end else begin
                        w_acc_next = r_acc | w_hit;
                        w_num_next = r_num + NUM_WIDTH'(1);
                    end
                    // The last beat's own contribution is loaded on the same
                    // edge that moves the FSM to HOLD.
                    if (idx_last_i) begin
                        w_state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (mask_ready_i) begin
                    w_acc_next   = '0;
                    w_num_next   = '0;
                    w_dup_next   = 1'b0;
                    w_err_next   = 1'b0;
                    w_state_next = ST_COLLECT;
                end
            end
            default: begin
                w_state_next = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_COLLECT;
            r_acc   <= '0;
            r_num   <= '0;
            r_dup   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_num   <= w_num_next;
            r_dup   <= w_dup_next;
            r_err   <= w_err_next;
        end
    end

    // All outputs come from registers or from the state. Nothing passes
    // combinationally from an input to an output.
    assign idx_ready_o  = (r_state == ST_COLLECT);
    assign mask_valid_o = (r_state == ST_HOLD);
    assign mask_o       = r_acc;
    assign num_o        = r_num;
    assign dup_o        = r_dup;
    assign err_o        = r_err;

    // A held mask stays valid and unchanged until the consumer takes it.
    a_hold_stable : assert property (@(posedge clk) disable iff (rst)
        (mask_valid_o && !mask_ready_i) |=> (mask_valid_o && $stable(mask_o)));

    // The bit count always agrees with the accumulated mask.
    a_num_matches : assert property (@(posedge clk) disable iff (rst)
        (num_o == NUM_WIDTH'($countones(mask_o))));

endmodule

// File: tb/tb_wired_index_collect.sv
module tb_wired_index_collect;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Three instances: WIDTH=8/MODE=0, WIDTH=8/MODE=1, WIDTH=6/MODE=0
    localparam int NI = 3;
    localparam int WK[NI] = '{8, 8, 6};
    localparam bit MK[NI] = '{1'b0, 1'b1, 1'b0};

    logic       vld  [NI];
    logic       last [NI];
    logic       mrdy [NI];
    logic [2:0] idx  [NI];

    logic       o_rdy  [NI];
    logic       o_mv   [NI];
    logic       o_dup  [NI];
    logic       o_err  [NI];
    logic [7:0] o_mask [NI];
    logic [3:0] o_num  [NI];
    logic [7:0] mask0, mask1;
    logic [3:0] num0, num1;
    logic [5:0] mask2;
    logic [2:0] num2;

    assign o_mask[0] = mask0;
    assign o_mask[1] = mask1;
    assign o_mask[2] = {2'b00, mask2};
    assign o_num[0]  = num0;
    assign o_num[1]  = num1;
    assign o_num[2]  = {1'b0, num2};

    wired_index_collect #(.WIDTH(8), .MODE(1'b0)) u_dut0 (
        .clk(clk), .rst(rst),
        .idx_valid_i(vld[0]), .idx_ready_o(o_rdy[0]), .idx_i(idx[0]), .idx_last_i(last[0]),
        .mask_valid_o(o_mv[0]), .mask_ready_i(mrdy[0]), .mask_o(mask0), .num_o(num0),
        .dup_o(o_dup[0]), .err_o(o_err[0])
    );

    wired_index_collect #(.WIDTH(8), .MODE(1'b1)) u_dut1 (
        .clk(clk), .rst(rst),
        .idx_valid_i(vld[1]), .idx_ready_o(o_rdy[1]), .idx_i(idx[1]), .idx_last_i(last[1]),
        .mask_valid_o(o_mv[1]), .mask_ready_i(mrdy[1]), .mask_o(mask1), .num_o(num1),
        .dup_o(o_dup[1]), .err_o(o_err[1])
    );

    wired_index_collect #(.WIDTH(6), .MODE(1'b0)) u_dut2 (
        .clk(clk), .rst(rst),
        .idx_valid_i(vld[2]), .idx_ready_o(o_rdy[2]), .idx_i(idx[2]), .idx_last_i(last[2]),
        .mask_valid_o(o_mv[2]), .mask_ready_i(mrdy[2]), .mask_o(mask2), .num_o(num2),
        .dup_o(o_dup[2]), .err_o(o_err[2])
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: each instance keeps the list of indices accepted in
    // the current frame and whether the frame is closed. Expected outputs
    // are recomputed from that list.
    // ------------------------------------------------------------------
    int fidx [NI][64];
    int fcnt [NI] = '{0, 0, 0};
    bit mhold[NI] = '{1'b0, 1'b0, 1'b0};

    initial forever begin
        @(posedge clk or posedge rst);
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                mhold[k] = 1'b0;
                fcnt[k]  = 0;
            end else if (mhold[k]) begin
                if (mrdy[k]) begin
                    mhold[k] = 1'b0;
                    fcnt[k]  = 0;
                end
            end else if (vld[k]) begin
                if (fcnt[k] < 64) begin
                    fidx[k][fcnt[k]] = int'(idx[k]);
                    fcnt[k]++;
                end
                if (last[k]) mhold[k] = 1'b1;
            end
        end
    end

    function automatic void model_out(input int k, output logic [7:0] m, output logic [3:0] n,
                                      output logic d, output logic e);
        m = '0;
        n = '0;
        d = 1'b0;
        e = 1'b0;
        for (int j = 0; j < fcnt[k]; j++) begin
            int i;
            int b;
            i = fidx[k][j];
            if (i >= WK[k]) begin
                e = 1'b1;
            end else begin
                b = MK[k] ? (WK[k] - 1 - i) : i;
                if (m[b]) d = 1'b1;
                else begin
                    m[b] = 1'b1;
                    n    = n + 4'd1;
                end
            end
        end
    endfunction

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            for (int k = 0; k < NI; k++) begin
                logic [7:0] em;
                logic [3:0] en;
                logic       ed;
                logic       ee;
                model_out(k, em, en, ed, ee);
                chk($sformatf("u%0d.ready", k), 32'(o_rdy[k]), 32'(!mhold[k]));
                chk($sformatf("u%0d.mask_valid", k), 32'(o_mv[k]), 32'(mhold[k]));
                chk($sformatf("u%0d.mask", k), 32'(o_mask[k]), 32'(em));
                chk($sformatf("u%0d.num", k), 32'(o_num[k]), 32'(en));
                chk($sformatf("u%0d.dup", k), 32'(o_dup[k]), 32'(ed));
                chk($sformatf("u%0d.err", k), 32'(o_err[k]), 32'(ee));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. They are entered and left 1 time unit after a
    // rising edge.
    // ------------------------------------------------------------------
    task automatic beat(input int k, input int i, input bit l);
        bit done;
        done    = 1'b0;
        vld[k]  = 1'b1;
        idx[k]  = 3'(i);
        last[k] = l;
        for (int c = 0; c < 50 && !done; c++) begin
            if (o_rdy[k]) done = 1'b1;
            @(posedge clk);
            #1;
        end
        vld[k]  = 1'b0;
        last[k] = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL beat_timeout u%0d: got no ready within 50 cycles, expected ready", k);
        end
    endtask

    task automatic take(input int k);
        mrdy[k] = 1'b1;
        @(posedge clk);
        #1;
        mrdy[k] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            vld[k] = 1'b0; last[k] = 1'b0; mrdy[k] = 1'b0; idx[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset.mask_valid", 32'(o_mv[0]), 32'd0);
        chk("reset.ready", 32'(o_rdy[0]), 32'd1);
        chk("reset.mask", 32'(o_mask[0]), 32'd0);
        chk("reset.num", 32'(o_num[0]), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic frame 3,0,7(last)
        beat(0, 3, 0); beat(0, 0, 0); beat(0, 7, 1);
        chk("basic.mask", 32'(o_mask[0]), 32'h89);
        chk("basic.num", 32'(o_num[0]), 32'd3);
        chk("basic.dup", 32'(o_dup[0]), 32'd0);
        chk("basic.ready", 32'(o_rdy[0]), 32'd0);
        chk("basic.mask_valid", 32'(o_mv[0]), 32'd1);

        // Backpressure: a pending beat must not be accepted while held
        vld[0] = 1'b1; idx[0] = 3'd1; last[0] = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp.mask", 32'(o_mask[0]), 32'h89);
            chk("bp.ready", 32'(o_rdy[0]), 32'd0);
        end
        vld[0] = 1'b0; last[0] = 1'b0;
        take(0);
        chk("bp.ready_after", 32'(o_rdy[0]), 32'd1);
        chk("bp.valid_after", 32'(o_mv[0]), 32'd0);
        chk("bp.mask_after", 32'(o_mask[0]), 32'd0);

        // MSB-based mapping
        beat(1, 0, 0); beat(1, 1, 1);
        chk("mode1.mask", 32'(o_mask[1]), 32'hC0);
        take(1);

        // Duplicates, then a clean frame
        beat(0, 5, 0); beat(0, 5, 1);
        chk("dup.mask", 32'(o_mask[0]), 32'h20);
        chk("dup.num", 32'(o_num[0]), 32'd1);
        chk("dup.dup", 32'(o_dup[0]), 32'd1);
        take(0);
        beat(0, 2, 1);
        chk("nodup.dup", 32'(o_dup[0]), 32'd0);
        chk("nodup.mask", 32'(o_mask[0]), 32'h04);
        take(0);

        // Out-of-range on WIDTH=6
        beat(2, 7, 1);
        chk("oor.mask", 32'(o_mask[2]), 32'd0);
        chk("oor.err", 32'(o_err[2]), 32'd1);
        chk("oor.num", 32'(o_num[2]), 32'd0);
        take(2);
        beat(2, 6, 0); beat(2, 5, 1);
        chk("oor_mix.mask", 32'(o_mask[2]), 32'h20);
        chk("oor_mix.err", 32'(o_err[2]), 32'd1);
        take(2);

        // Round trip through trailing-/leading-zero counts
        for (int r = 0; r < 7; r++) begin
            logic [7:0] v;
            int tz;
            int lz;
            v  = 8'(1 << r);
            tz = 0;
            while (tz < 7 && !v[tz]) tz++;
            lz = 0;
            while (lz < 8 && !v[7 - lz]) lz++;
            beat(0, tz, 1);
            beat(1, lz, 1);
            chk($sformatf("rt_tz%0d.mask", r), 32'(o_mask[0]), 32'(v));
            chk($sformatf("rt_lz%0d.mask", r), 32'(o_mask[1]), 32'(v));
            take(0);
            take(1);
        end

        // Reset in the middle of a frame
        beat(0, 1, 0); beat(0, 4, 0);
        rst = 1'b1;
        #1;
        chk("midrst.mask", 32'(o_mask[0]), 32'd0);
        chk("midrst.num", 32'(o_num[0]), 32'd0);
        chk("midrst.valid", 32'(o_mv[0]), 32'd0);
        chk("midrst.ready", 32'(o_rdy[0]), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        beat(0, 6, 1);
        chk("postrst.mask", 32'(o_mask[0]), 32'h40);
        chk("postrst.num", 32'(o_num[0]), 32'd1);
        take(0);

        // Randomised traffic on all instances, with one reset pulse
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < NI; k++) begin
                vld[k]  = ($urandom_range(0, 3) != 0);
                idx[k]  = 3'($urandom_range(0, 7));
                last[k] = ($urandom_range(0, 3) == 0) || (fcnt[k] >= 40);
                mrdy[k] = ($urandom_range(0, 1) == 1);
            end
            rst = (cyc == 1500);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            vld[k] = 1'b0; last[k] = 1'b0; mrdy[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
